// File: rtl/conv_sequencer_pkg.sv
// Shared definitions for the frame sequencer: FSM state encoding, kernel-select
// codes and helpers for the derived frame geometry.
// No ports; imported by conv_sequencer and conv_addr_gen.
package conv_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Kernel-select codes passed through to the convolver.
    localparam logic [1:0] KSEL_IDENTITY = 2'b00;
    localparam logic [1:0] KSEL_EDGE     = 2'b01;
    localparam logic [1:0] KSEL_SHARPEN  = 2'b10;
    localparam logic [1:0] KSEL_BLUR     = 2'b11;

    // Number of vertically valid output rows (NUM_OUT_ROWS).
    function automatic int num_out_rows(input int h, input int k);
        return h - k + 1;
    endfunction

    // Columns presented per frame (COLS_PER_FRAME).
    function automatic int cols_per_frame(input int w, input int h, input int k);
        return (h - k + 1) * w;
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Scan counters for the sequencer: row, column, row base and kernel-row offset,
// all advanced with adders only. Address is combinational from the counters.
// Ports: i_clear restarts the scan, i_step_k advances k (wraps at K-1),
// i_step_col advances the column and, at the row end, the row.
// o_addr = row_base + k*W + c; o_last_k/o_last_col/o_last_row flag scan ends.
module conv_addr_gen
    import conv_sequencer_pkg::*;
#(
    parameter int NB_ADDR      = 10,
    parameter int IMAGE_WIDTH  = 10,
    parameter int IMAGE_HEIGHT = 10,
    parameter int KERNEL_WIDTH = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_step_k,
    input  logic               i_step_col,
    output logic [NB_ADDR-1:0] o_addr,
    output logic [1:0]         o_k,
    output logic               o_last_k,
    output logic               o_last_col,
    output logic               o_last_row
);

    localparam logic [NB_ADDR-1:0] W_STEP = NB_ADDR'(IMAGE_WIDTH);
    localparam logic [NB_ADDR-1:0] LAST_C = NB_ADDR'(IMAGE_WIDTH - 1);
    localparam logic [NB_ADDR-1:0] LAST_R = NB_ADDR'(num_out_rows(IMAGE_HEIGHT, KERNEL_WIDTH) - 1);
    localparam logic [1:0]         LAST_K = 2'(KERNEL_WIDTH - 1);

    logic [NB_ADDR-1:0] r_row;
    logic [NB_ADDR-1:0] r_col;
    logic [NB_ADDR-1:0] r_row_base;
    logic [NB_ADDR-1:0] r_k_ofs;     // k*W, tracked incrementally
    logic [1:0]         r_k;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_row      <= '0;
            r_col      <= '0;
            r_row_base <= '0;
            r_k_ofs    <= '0;
            r_k        <= '0;
        end else begin
            if (i_step_k) begin
                if (r_k == LAST_K) begin
                    r_k     <= '0;
                    r_k_ofs <= '0;
                end else begin
                    r_k     <= r_k + 2'd1;
                    r_k_ofs <= r_k_ofs + W_STEP;
                end
            end
            if (i_step_col) begin
                if (r_col == LAST_C) begin
                    r_col <= '0;
                    // On the final row the scan ends; counters are left as-is
                    // and cleared by the next accepted start.
                    if (r_row != LAST_R) begin
                        r_row      <= r_row + NB_ADDR'(1);
                        r_row_base <= r_row_base + W_STEP;
                    end
                end else begin
                    r_col <= r_col + NB_ADDR'(1);
                end
            end
        end
    end

    assign o_addr     = r_row_base + r_k_ofs + r_col;
    assign o_k        = r_k;
    assign o_last_k   = (r_k == LAST_K);
    assign o_last_col = (r_col == LAST_C);
    assign o_last_row = (r_row == LAST_R);

endmodule

// File: rtl/conv_sequencer.sv
// Frame sequencer: scans the loaded frame, reads K=3 vertically adjacent pixels
// per column from the BRAM and presents each column to the convolver.
// Latency: 5 cycles per column unstalled; stalls only in PRESENT on i_conv_ready=0.
// Ports: i_start_conv/i_kernel_sel/i_frame_ready from the file register;
// o_rd_en/o_rd_addr/i_rd_data to the BRAM read port (1-cycle read latency);
// o_col_valid/i_conv_ready/o_col0..2/o_kernel_sel to the convolver;
// o_busy/o_done/o_err status.
module conv_sequencer
    import conv_sequencer_pkg::*;
#(
    parameter int RAM_WIDTH    = 8,
    parameter int RAM_DEPTH    = 1024,
    parameter int NB_ADDR      = 10,
    parameter int IMAGE_WIDTH  = 10,
    parameter int IMAGE_HEIGHT = 10,
    parameter int KERNEL_WIDTH = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_start_conv,
    input  logic [1:0]           i_kernel_sel,
    input  logic                 i_frame_ready,
    output logic                 o_rd_en,
    output logic [NB_ADDR-1:0]   o_rd_addr,
    input  logic [RAM_WIDTH-1:0] i_rd_data,
    output logic                 o_col_valid,
    input  logic                 i_conv_ready,
    output logic [RAM_WIDTH-1:0] o_col0,
    output logic [RAM_WIDTH-1:0] o_col1,
    output logic [RAM_WIDTH-1:0] o_col2,
    output logic [1:0]           o_kernel_sel,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    // Frame must fit the BRAM and the address width; three column outputs fix K.
    if ((IMAGE_HEIGHT * IMAGE_WIDTH > RAM_DEPTH) || ((2 ** NB_ADDR) < RAM_DEPTH) ||
        (KERNEL_WIDTH != 3)) begin : g_bad_cfg
        $error("conv_sequencer: unsupported parameter set");
    end

    state_t r_state;
    state_t w_next;

    logic               w_accept;
    logic               w_clear;
    logic               w_step_k;
    logic               w_step_col;
    logic               w_rd_en;
    logic [NB_ADDR-1:0] w_addr;
    logic [1:0]         w_k;
    logic               w_last_k;
    logic               w_last_col;
    logic               w_last_row;

    logic                 r_cap_vld;   // read data arrives this cycle
    logic [1:0]           r_cap_slot;  // k of that read
    logic [RAM_WIDTH-1:0] r_col0;
    logic [RAM_WIDTH-1:0] r_col1;
    logic [RAM_WIDTH-1:0] r_col2;
    logic [1:0]           r_kernel_sel;
    logic                 r_err;

    conv_addr_gen #(
        .NB_ADDR      (NB_ADDR),
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT),
        .KERNEL_WIDTH (KERNEL_WIDTH)
    ) u_addr_gen (
        .clock      (clock),
        .reset      (reset),
        .i_clear    (w_clear),
        .i_step_k   (w_step_k),
        .i_step_col (w_step_col),
        .o_addr     (w_addr),
        .o_k        (w_k),
        .o_last_k   (w_last_k),
        .o_last_col (w_last_col),
        .o_last_row (w_last_row)
    );

    assign w_accept = (r_state == ST_IDLE) && i_start_conv && i_frame_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_clear    = 1'b0;
        w_step_k   = 1'b0;
        w_step_col = 1'b0;
        w_rd_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_clear = 1'b1;
                    w_next  = ST_READ;
                end
            end
            ST_READ: begin
                w_rd_en  = 1'b1;
                w_step_k = 1'b1;
                if (w_last_k) begin
                    w_next = ST_WAIT;
                end
            end
            // Drains the last read of the column into slot 2.
            ST_WAIT: w_next = ST_PRESENT;
            ST_PRESENT: begin
                if (i_conv_ready) begin
                    w_step_col = 1'b1;
                    w_next     = (w_last_col && w_last_row) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Capture, start-latch and error registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cap_vld    <= 1'b0;
            r_cap_slot   <= '0;
            r_col0       <= '0;
            r_col1       <= '0;
            r_col2       <= '0;
            r_kernel_sel <= '0;
            r_err        <= 1'b0;
        end else begin
            r_cap_vld  <= w_rd_en;
            r_cap_slot <= w_k;
            if (r_cap_vld) begin
                case (r_cap_slot)
                    2'd0:    r_col0 <= i_rd_data;
                    2'd1:    r_col1 <= i_rd_data;
                    default: r_col2 <= i_rd_data;
                endcase
            end
            if (w_accept) begin
                r_kernel_sel <= i_kernel_sel;
            end
            // Any start that is not accepted (busy or frame not loaded).
            r_err <= i_start_conv && !w_accept;
        end
    end

    assign o_rd_en      = w_rd_en;
    assign o_rd_addr    = w_rd_en ? w_addr : '0;
    assign o_col_valid  = (r_state == ST_PRESENT);
    assign o_col0       = r_col0;
    assign o_col1       = r_col1;
    assign o_col2       = r_col2;
    assign o_kernel_sel = r_kernel_sel;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = (r_state == ST_DONE);
    assign o_err        = r_err;

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: frame scenarios from a vector table plus reset,
// rejected-start and mid-frame-abort sequences, checked against a frame model.
module tb_conv_sequencer;

    localparam int RW     = 8;
    localparam int RD     = 1024;
    localparam int NA     = 10;
    localparam int W      = 10;
    localparam int H      = 10;
    localparam int K      = 3;
    localparam int NCOL   = (H - K + 1) * W;
    localparam int BUDGET = 3000;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    ksel;
    logic          fr;
    logic          rd_en;
    logic [NA-1:0] rd_addr;
    logic [RW-1:0] rd_data = '0;
    logic          col_valid;
    logic          ready;
    logic [RW-1:0] col0, col1, col2;
    logic [1:0]    kernel_sel_o;
    logic          busy, done, err;

    conv_sequencer #(
        .RAM_WIDTH(RW), .RAM_DEPTH(RD), .NB_ADDR(NA),
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .KERNEL_WIDTH(K)
    ) dut (
        .clock(clock), .reset(reset), .i_start_conv(start), .i_kernel_sel(ksel),
        .i_frame_ready(fr), .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
        .o_col_valid(col_valid), .i_conv_ready(ready), .o_col0(col0), .o_col1(col1),
        .o_col2(col2), .o_kernel_sel(kernel_sel_o), .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // BRAM model: data = low byte of the address, one cycle after the read.
    always @(posedge clock) if (rd_en) rd_data <= rd_addr[7:0];

    int checks = 0;
    int failures = 0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    typedef struct {
        logic [1:0] ksel;
        int         lo_start;     // first cycle with ready low (deterministic rows)
        int         lo_len;
        bit         rnd;          // random ready pattern
        int         extra_start;  // cycle of a start while busy, -1 none
        int         exp_done;     // expected o_done cycle, 0 = from model
        int         exp_err;
    } frame_vec_t;

    frame_vec_t vecs[5];
    int spot_idx[12];
    int spot_val[12];
    bit pat[BUDGET];

    // Model: each column needs 3 reads + 1 wait, then sits in PRESENT until
    // a cycle where ready is high; done follows the last transfer.
    function automatic int model_done();
        int t = 1;
        int p;
        for (int col = 0; col < NCOL; col++) begin
            p = t + 4;
            while (p < BUDGET - 1 && !pat[p]) p++;
            t = p + 1;
        end
        return t;
    endfunction

    // Read address i of the frame: column j = i/3 at row r=j/W, col c=j%W, row k=i%3.
    function automatic int exp_addr(input int i);
        int j = i / 3;
        return (j / W) * W + (j % W) + (i % 3) * W;
    endfunction

    task automatic run_frame(input frame_vec_t v, input string tag);
        int s, n, done_n, exp;
        int errs = 0, rises = 0, bad_idle = 0, over = 0, rd_in_present = 0, unstable = 0;
        int bad_addr = 0, bad_col = 0, a;
        int qa[$];
        int qc0[$], qc1[$], qc2[$];
        bit prev_v = 0, prev_r = 0, seen_done = 0, busy_at_done = 0;
        logic [RW-1:0] p0 = '0, p1 = '0, p2 = '0;
        done_n = -1;
        for (int i = 0; i < BUDGET; i++)
            pat[i] = v.rnd ? ($urandom_range(0, 3) != 0)
                           : !(i >= v.lo_start && i < v.lo_start + v.lo_len);
        exp = (v.exp_done != 0) ? v.exp_done : model_done();

        @(negedge clock);
        check({tag, "_idle_busy"}, int'(busy), 0);
        start = 1'b1; fr = 1'b1; ksel = v.ksel; ready = pat[0]; s = cyc; n = 0;
        while (!seen_done && n < BUDGET - 1) begin
            @(negedge clock);
            n     = cyc - s;
            start = (n == v.extra_start);
            fr    = (n < 30 || n >= 40);
            ksel  = 2'(n);
            ready = pat[n];
            if (rd_en) begin
                qa.push_back(int'(rd_addr));
                if (int'(rd_addr) >= RD) over++;
            end else if (rd_addr != '0) begin
                bad_idle++;
            end
            if (col_valid && rd_en) rd_in_present++;
            if (col_valid && !prev_v) rises++;
            if (col_valid && prev_v && !prev_r && (col0 != p0 || col1 != p1 || col2 != p2))
                unstable++;
            if (col_valid && ready) begin
                qc0.push_back(int'(col0)); qc1.push_back(int'(col1)); qc2.push_back(int'(col2));
            end
            if (err) errs++;
            if (done) begin
                seen_done = 1; done_n = n; busy_at_done = busy;
            end
            prev_v = col_valid; prev_r = ready; p0 = col0; p1 = col1; p2 = col2;
        end
        start = 1'b0; fr = 1'b1;

        check({tag, "_timeout"}, int'(seen_done), 1);
        check({tag, "_done_cycle"}, done_n, exp);
        check({tag, "_busy_at_done"}, int'(busy_at_done), 1);
        check({tag, "_kernel_sel"}, int'(kernel_sel_o), int'(v.ksel));
        check({tag, "_err_pulses"}, errs, v.exp_err);
        check({tag, "_valid_rises"}, rises, NCOL);
        check({tag, "_col_count"}, qc0.size(), NCOL);
        check({tag, "_addr_count"}, qa.size(), 3 * NCOL);
        for (int i = 0; i < qa.size() && i < 3 * NCOL; i++)
            if (qa[i] != exp_addr(i)) bad_addr++;
        check({tag, "_addr_seq_mismatches"}, bad_addr, 0);
        for (int i = 0; i < 12; i++)
            check($sformatf("%s_addr%0d", tag, spot_idx[i]),
                  (spot_idx[i] < qa.size()) ? qa[spot_idx[i]] : -1, spot_val[i]);
        for (int j = 0; j < qc0.size() && j < NCOL; j++) begin
            a = (j / W) * W + (j % W);
            if (qc0[j] != (a & 255) || qc1[j] != ((a + W) & 255) || qc2[j] != ((a + 2 * W) & 255))
                bad_col++;
        end
        check({tag, "_col_data_mismatches"}, bad_col, 0);
        check({tag, "_addr_nonzero_idle"}, bad_idle, 0);
        check({tag, "_addr_out_of_range"}, over, 0);
        check({tag, "_read_while_presenting"}, rd_in_present, 0);
        check({tag, "_unstable_during_stall"}, unstable, 0);
    endtask

    task automatic abort_frame(input int abort_n);
        int s, n = 0, dones = 0, busy_after = 0;
        @(negedge clock);
        start = 1'b1; fr = 1'b1; ksel = 2'b11; ready = 1'b1; s = cyc;
        while (n < abort_n + 12) begin
            @(negedge clock);
            n = cyc - s;
            start = 1'b0;
            if (done) dones++;
            if (n == abort_n) begin
                check("abort_busy_before", int'(busy), 1);
                reset = 1'b1;
            end
            if (n == abort_n + 1) begin
                reset = 1'b0;
                check("abort_outputs_zero",
                      int'({rd_en, rd_addr, col_valid, col0, col1, col2,
                            kernel_sel_o, busy, done, err} != '0), 0);
            end
            if (n > abort_n + 1 && busy) busy_after++;
        end
        check("abort_no_done", dones, 0);
        check("abort_stays_idle", busy_after, 0);
    endtask

    initial begin
        int err_cnt = 0, busy_cnt = 0;
        vecs[0] = '{2'b10, -1, 0, 1'b0, -1, 401, 0};
        vecs[1] = '{2'b01, 20, 7, 1'b0, -1, 408, 0};
        vecs[2] = '{2'b11, -1, 0, 1'b0, 50, 401, 1};
        vecs[3] = '{2'b00, -1, 0, 1'b1, -1, 0, 0};
        vecs[4] = '{2'b10, -1, 0, 1'b1, 77, 0, 1};
        spot_idx = '{0, 1, 2, 3, 4, 5, 30, 31, 32, 237, 238, 239};
        spot_val = '{0, 10, 20, 1, 11, 21, 10, 20, 30, 79, 89, 99};

        reset = 1'b1; start = 1'b0; fr = 1'b0; ksel = 2'b00; ready = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_rd_en", int'(rd_en), 0);
        check("reset_rd_addr", int'(rd_addr), 0);
        check("reset_col_valid", int'(col_valid), 0);
        check("reset_cols", int'({col0, col1, col2}), 0);
        check("reset_kernel_sel", int'(kernel_sel_o), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done_err", int'({done, err}), 0);
        reset = 1'b0;

        // Start without a loaded frame: one error pulse, never busy.
        @(negedge clock);
        start = 1'b1; fr = 1'b0; ksel = 2'b01;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clock);
                start = 1'b0;
            end
            if (err) err_cnt++;
            if (busy) busy_cnt++;
        end
        check("reject_err_pulses", err_cnt, 1);
        check("reject_busy_cycles", busy_cnt, 0);
        check("reject_kernel_sel", int'(kernel_sel_o), 0);

        // Table frames run back-to-back: each start follows the previous o_done.
        for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("f%0d", i));

        abort_frame(123);
        run_frame(vecs[0], "restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
